mac_array_engine: RTL

//  Parametrised successor to the fixed 3-PE conv/FCN datapath. NUM_PE signed MAC lanes

---
 rtl/mac_array_engine.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mac_array_engine.sv
// Multi-lane signed MAC engine: NUM_PE lanes reduced per beat, accumulated over cfg_len beats,
// then shifted, optionally rectified and saturated into a valid/ready result stream.
module mac_array_engine #(
  parameter int NUM_PE = 4,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int LEN_W  = 10,
  parameter int CNT_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [CNT_W-1:0]      cfg_num_out,
  input  logic [4:0]            cfg_shift,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_PE*8-1:0]   in_act,
  input  logic [NUM_PE*8-1:0]   in_wgt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // 9b x 8b products are 17b; one extra bit per doubling of lanes, plus margin.
  localparam int SUM_W = 17 + $clog2(NUM_PE) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [LEN_W-1:0]         len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]         num_q, num_d, out_cnt_q, out_cnt_d;
  logic [4:0]               shift_q, shift_d;
  logic                     flush_q, flush_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     done_q, done_d, err_q, err_d;
  logic                     acc_clr, accept;

  logic signed [SUM_W-1:0]  prod [NUM_PE];
  logic signed [SUM_W-1:0]  lane_sum, s1_sum_q;
  logic                     s1_vld_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d, shifted;
  logic                     sat_q, sat_d;
  logic signed [ACC_W:0]    acc_sum;
  logic [ACC_W-OUT_W:0]     hi_bits;
  logic [OUT_W-1:0]         result;

  assign accept = in_valid && in_ready;

  // Activation sign-extends only in FCN modes (mode bit 1); weights are always signed.
  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
    logic signed [SUM_W-1:0] act_x, wgt_x;
    assign act_x    = {{(SUM_W-8){mode_q[1] & in_act[8*gi+7]}}, in_act[8*gi +: 8]};
    assign wgt_x    = {{(SUM_W-8){in_wgt[8*gi+7]}}, in_wgt[8*gi +: 8]};
    assign prod[gi] = act_x * wgt_x;
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < NUM_PE; i++) lane_sum = lane_sum + prod[i];
  end

  // Once the accumulator clips it stays clipped until the next result starts.
  always_comb begin
    acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-SUM_W){s1_sum_q[SUM_W-1]}}, s1_sum_q};
    acc_d   = acc_q;
    sat_d   = sat_q;
    if (acc_clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (s1_vld_q && !sat_q) begin
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
        acc_d = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        sat_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
    end
  end

  always_comb begin
    shifted = acc_q >>> shift_q;
    hi_bits = shifted[ACC_W-1:OUT_W-1];
    if (!mode_q[0] && shifted[ACC_W-1])
      result = '0;
    else if ((&hi_bits) || !(|hi_bits))
      result = shifted[OUT_W-1:0];
    else
      result = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    num_d       = num_q;
    shift_d     = shift_q;
    beat_cnt_d  = beat_cnt_q;
    out_cnt_d   = out_cnt_q;
    flush_d     = flush_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    err_d       = start && (state_q != S_IDLE);
    acc_clr     = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        mode_d     = cfg_mode;
        len_d      = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        num_d      = (cfg_num_out == '0) ? CNT_W'(1) : cfg_num_out;
        shift_d    = cfg_shift;
        beat_cnt_d = '0;
        out_cnt_d  = '0;
        acc_clr    = 1'b1;
        state_d    = S_ACCUM;
      end
      S_ACCUM: if (accept) begin
        if (beat_cnt_q == len_q - LEN_W'(1)) begin
          flush_d = 1'b0;
          state_d = S_FLUSH;
        end else begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
        end
      end
      // First FLUSH cycle lets S1 feed the accumulator; the second sees the final sum.
      S_FLUSH: begin
        if (!flush_q) begin
          flush_d = 1'b1;
        end else begin
          out_data_d  = result;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        if (out_cnt_q == num_q - CNT_W'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          out_cnt_d  = out_cnt_q + CNT_W'(1);
          beat_cnt_d = '0;
          acc_clr    = 1'b1;
          state_d    = S_ACCUM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      len_q       <= '0;
      num_q       <= '0;
      shift_q     <= '0;
      beat_cnt_q  <= '0;
      out_cnt_q   <= '0;
      flush_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      s1_sum_q    <= '0;
      s1_vld_q    <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      num_q       <= num_d;
      shift_q     <= shift_d;
      beat_cnt_q  <= beat_cnt_d;
      out_cnt_q   <= out_cnt_d;
      flush_q     <= flush_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      s1_vld_q    <= accept;
      if (accept) s1_sum_q <= lane_sum;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
